memory_access: RTL and testbench

Pipeline stage 4: consumes the latched execute-stage result bundle and performs RV64 loads and stores on a single-port, 64-bit data-memory bus. Non-memory results pass through. The block stalls upstream while an access is in flight and presents a latched bundle to writeback. It is the consumer end of execute's `*_q` interface and its `stall_in`/`stall_out` chain.

---
 rtl/instruction_decode_types.sv | 19 +
 rtl/load_align.sv | 20 ++
 rtl/memory_access.sv | 126 ++++++++++++
 tb/tb_memory_access.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_types.sv
// instruction_decode_types: shared decode enums plus load/store sizing helpers.
package instruction_decode_types;
    typedef enum logic [3:0] {
        LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
    } load_store_variant_e;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} mem_state_e;
    // log2 of the access size in bytes
    function automatic logic [1:0] ls_size(load_store_variant_e v);
        return (v == LB || v == LBU || v == SB) ? 2'd0 :
               (v == LH || v == LHU || v == SH) ? 2'd1 :
               (v == LW || v == LWU || v == SW) ? 2'd2 : 2'd3;
    endfunction
    function automatic logic ls_misaligned(load_store_variant_e v, logic [2:0] off);
        return |(off & ((3'd1 << ls_size(v)) - 3'd1));
    endfunction
    function automatic logic [7:0] ls_strb(load_store_variant_e v);
        return (8'd1 << (4'd1 << ls_size(v))) - 8'd1;
    endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed bytes out of a 64-bit read and extends them.
module load_align
    import instruction_decode_types::*;
(
    input  logic [63:0]         rdata,
    input  logic [2:0]          byte_off,
    input  load_store_variant_e variant,
    output logic [63:0]         double_word
);
    logic [63:0] w_shifted;
    always_comb begin
        w_shifted   = rdata >> {byte_off, 3'b000};
        double_word = variant == LB  ? {{56{w_shifted[7]}},  w_shifted[7:0]}  :
                      variant == LH  ? {{48{w_shifted[15]}}, w_shifted[15:0]} :
                      variant == LW  ? {{32{w_shifted[31]}}, w_shifted[31:0]} :
                      variant == LBU ? {56'h0, w_shifted[7:0]}                :
                      variant == LHU ? {48'h0, w_shifted[15:0]}               :
                      variant == LWU ? {32'h0, w_shifted[31:0]}               : w_shifted;
    end
endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline stage 4, RV64 loads/stores on a single-port 64-bit bus
// with pass-through of non-memory results and a latched writeback bundle.
module memory_access
    import instruction_decode_types::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [4:0]          in_rd,
    input  logic [63:0]         in_result,
    input  logic                in_write_to_rd,
    input  logic                in_is_mem_addr,
    input  logic                in_mem_is_write,
    input  logic [63:0]         in_store_data,
    input  load_store_variant_e in_ls_variant,
    input  logic                in_is_final,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [63:0]         req_addr,
    output logic                req_write,
    output logic [63:0]         req_wdata,
    output logic [7:0]          req_wstrb,
    input  logic                resp_valid,
    input  logic [63:0]         resp_rdata,
    output logic                wb_valid_q,
    output logic [4:0]          wb_rd_q,
    output logic [63:0]         wb_data_q,
    output logic                wb_write_to_rd_q,
    output logic                wb_is_final_q,
    output logic                wb_fault_q,
    input  logic                stall_in,
    output logic                stall_out
);
    mem_state_e          r_state;
    logic                r_req_valid;
    logic [63:0]         r_addr;
    logic [63:0]         r_store_data;
    logic [63:0]         r_load_data;
    load_store_variant_e r_variant;
    logic [4:0]          r_rd;
    logic                r_wtr;
    logic                r_final;
    logic                r_is_write;
    logic                w_direct;
    logic [63:0]         w_load;

    load_align u_align (
        .rdata      (resp_rdata),
        .byte_off   (r_addr[2:0]),
        .variant    (r_variant),
        .double_word(w_load)
    );

    // Non-memory ops and misaligned accesses retire without touching the bus
    assign w_direct  = !in_is_mem_addr || ls_misaligned(in_ls_variant, in_result[2:0]);
    assign req_valid = r_req_valid;
    assign req_addr  = {r_addr[63:3], 3'b000};
    assign req_write = r_is_write;
    assign req_wdata = r_store_data << {r_addr[2:0], 3'b000};
    assign req_wstrb = r_is_write ? ls_strb(r_variant) << r_addr[2:0] : 8'h00;
    assign stall_out = stall_in || r_state != S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_req_valid      <= 1'b0;
            r_addr           <= '0;
            r_store_data     <= '0;
            r_load_data      <= '0;
            r_variant        <= LB;
            r_rd             <= '0;
            r_wtr            <= 1'b0;
            r_final          <= 1'b0;
            r_is_write       <= 1'b0;
            wb_valid_q       <= 1'b0;
            wb_rd_q          <= '0;
            wb_data_q        <= '0;
            wb_write_to_rd_q <= 1'b0;
            wb_is_final_q    <= 1'b0;
            wb_fault_q       <= 1'b0;
        end else begin
            if (!stall_in)
                wb_valid_q <= 1'b0;
            case (r_state)
                S_IDLE: if (!stall_in && in_valid) begin
                    if (w_direct) begin
                        wb_valid_q       <= 1'b1;
                        wb_rd_q          <= in_rd;
                        wb_data_q        <= in_result;
                        wb_write_to_rd_q <= in_write_to_rd && !in_is_mem_addr;
                        wb_is_final_q    <= in_is_final;
                        wb_fault_q       <= in_is_mem_addr;
                    end else begin
                        r_addr       <= in_result;
                        r_store_data <= in_store_data;
                        r_variant    <= in_ls_variant;
                        r_rd         <= in_rd;
                        r_wtr        <= in_write_to_rd;
                        r_final      <= in_is_final;
                        r_is_write   <= in_mem_is_write;
                        r_req_valid  <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: if (req_ready) begin
                    r_req_valid <= 1'b0;
                    r_state     <= r_is_write ? S_DONE : S_RESP;
                end
                S_RESP: if (resp_valid) begin
                    r_load_data <= w_load;
                    r_state     <= S_DONE;
                end
                S_DONE: if (!stall_in) begin
                    wb_valid_q       <= 1'b1;
                    wb_rd_q          <= r_rd;
                    wb_data_q        <= r_is_write ? 64'h0 : r_load_data;
                    wb_write_to_rd_q <= r_wtr && !r_is_write;
                    wb_is_final_q    <= r_final;
                    wb_fault_q       <= 1'b0;
                    r_state          <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vectors with hand-computed expectations for memory_access.
module tb_memory_access;
    import instruction_decode_types::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [4:0]          in_rd = '0;
    logic [63:0]         in_result = '0;
    logic                in_write_to_rd = 1'b0;
    logic                in_is_mem_addr = 1'b0;
    logic                in_mem_is_write = 1'b0;
    logic [63:0]         in_store_data = '0;
    load_store_variant_e in_ls_variant = LB;
    logic                in_is_final = 1'b0;
    logic                req_valid;
    logic                req_ready = 1'b0;
    logic [63:0]         req_addr;
    logic                req_write;
    logic [63:0]         req_wdata;
    logic [7:0]          req_wstrb;
    logic                resp_valid = 1'b0;
    logic [63:0]         resp_rdata = '0;
    logic                wb_valid_q;
    logic [4:0]          wb_rd_q;
    logic [63:0]         wb_data_q;
    logic                wb_write_to_rd_q;
    logic                wb_is_final_q;
    logic                wb_fault_q;
    logic                stall_in = 1'b0;
    logic                stall_out;
    int                  n_checks = 0;
    int                  n_errors = 0;

    memory_access dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_rd(in_rd), .in_result(in_result),
        .in_write_to_rd(in_write_to_rd), .in_is_mem_addr(in_is_mem_addr),
        .in_mem_is_write(in_mem_is_write), .in_store_data(in_store_data),
        .in_ls_variant(in_ls_variant), .in_is_final(in_is_final),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .wb_valid_q(wb_valid_q), .wb_rd_q(wb_rd_q), .wb_data_q(wb_data_q),
        .wb_write_to_rd_q(wb_write_to_rd_q), .wb_is_final_q(wb_is_final_q),
        .wb_fault_q(wb_fault_q), .stall_in(stall_in), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one bundle for exactly one clock edge
    task automatic issue(input logic mem, input logic wr, input load_store_variant_e v,
                         input logic [63:0] res, input logic [63:0] sd, input logic [4:0] rd);
        in_valid = 1'b1; in_is_mem_addr = mem; in_mem_is_write = wr; in_ls_variant = v;
        in_result = res; in_store_data = sd; in_rd = rd; in_write_to_rd = !wr; in_is_final = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_wb_valid", {63'h0, wb_valid_q}, 64'h0);
        check("rst_req_valid", {63'h0, req_valid}, 64'h0);
        check("rst_wb_data", wb_data_q, 64'h0);
        check("rst_stall_out", {63'h0, stall_out}, 64'h0);
        rst_n = 1'b1;
        tick();

        issue(1'b0, 1'b0, LB, 64'h1234, 64'h0, 5'd5);
        check("alu_valid", {63'h0, wb_valid_q}, 64'h1);
        check("alu_data", wb_data_q, 64'h1234);
        check("alu_rd", {59'h0, wb_rd_q}, 64'd5);
        check("alu_stall", {63'h0, stall_out}, 64'h0);

        issue(1'b1, 1'b0, LB, 64'h1003, 64'h0, 5'd6);
        check("lb_req_valid", {63'h0, req_valid}, 64'h1);
        check("lb_req_addr", req_addr, 64'h1000);
        check("lb_wstrb", {56'h0, req_wstrb}, 64'h0);
        check("lb_stall", {63'h0, stall_out}, 64'h1);
        check("lb_bubble", {63'h0, wb_valid_q}, 64'h0);
        tick();
        check("lb_req_hold", {63'h0, req_valid}, 64'h1);
        check("lb_addr_hold", req_addr, 64'h1000);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("lb_req_drop", {63'h0, req_valid}, 64'h0);
        tick();
        check("lb_wait_resp", {63'h0, wb_valid_q}, 64'h0);
        resp_valid = 1'b1; resp_rdata = 64'h0000_0000_8000_0000;
        tick();
        resp_valid = 1'b0;
        check("lb_done_stall", {63'h0, stall_out}, 64'h1);
        tick();
        check("lb_valid", {63'h0, wb_valid_q}, 64'h1);
        check("lb_data", wb_data_q, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_rd", {59'h0, wb_rd_q}, 64'd6);
        check("lb_stall_free", {63'h0, stall_out}, 64'h0);

        issue(1'b1, 1'b0, LWU, 64'h2004, 64'h0, 5'd7);
        req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 64'h1111_1111_2222_2222;
        tick();
        req_ready = 1'b0; resp_rdata = 64'hDEAD_BEEF_0000_0000;
        tick();
        resp_valid = 1'b0;
        check("lwu_not_yet", {63'h0, wb_valid_q}, 64'h0);
        tick();
        check("lwu_valid", {63'h0, wb_valid_q}, 64'h1);
        check("lwu_data", wb_data_q, 64'h0000_0000_DEAD_BEEF);

        issue(1'b1, 1'b1, SH, 64'h3006, 64'hABCD, 5'd8);
        check("sh_write", {63'h0, req_write}, 64'h1);
        check("sh_addr", req_addr, 64'h3000);
        check("sh_wstrb", {56'h0, req_wstrb}, 64'hC0);
        check("sh_wdata", req_wdata, 64'hABCD_0000_0000_0000);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("sh_done_bubble", {63'h0, wb_valid_q}, 64'h0);
        tick();
        check("sh_valid", {63'h0, wb_valid_q}, 64'h1);
        check("sh_wtr", {63'h0, wb_write_to_rd_q}, 64'h0);
        check("sh_data", wb_data_q, 64'h0);

        issue(1'b1, 1'b1, SB, 64'h6005, 64'h1122_3344_5566_77EE, 5'd0);
        check("sb_wstrb", {56'h0, req_wstrb}, 64'h20);
        check("sb_wdata", req_wdata, 64'h6677_EE00_0000_0000);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        check("sb_valid", {63'h0, wb_valid_q}, 64'h1);

        issue(1'b1, 1'b0, LW, 64'h4002, 64'h0, 5'd9);
        check("mis_req", {63'h0, req_valid}, 64'h0);
        check("mis_valid", {63'h0, wb_valid_q}, 64'h1);
        check("mis_fault", {63'h0, wb_fault_q}, 64'h1);
        check("mis_wtr", {63'h0, wb_write_to_rd_q}, 64'h0);
        check("mis_stall", {63'h0, stall_out}, 64'h0);

        stall_in = 1'b1;
        issue(1'b0, 1'b0, LB, 64'h9999, 64'h0, 5'd1);
        check("idle_stall_valid", {63'h0, wb_valid_q}, 64'h1);
        check("idle_stall_fault", {63'h0, wb_fault_q}, 64'h1);
        check("idle_stall_out", {63'h0, stall_out}, 64'h1);
        stall_in = 1'b0;

        issue(1'b1, 1'b0, LH, 64'h5002, 64'h0, 5'd10);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 64'h0000_0000_F00D_0000;
        tick();
        resp_valid = 1'b0; stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_stall_valid", {63'h0, wb_valid_q}, 64'h0);
            check("done_stall_rd", {59'h0, wb_rd_q}, 64'd9);
        end
        stall_in = 1'b0;
        tick();
        check("lh_valid", {63'h0, wb_valid_q}, 64'h1);
        check("lh_data", wb_data_q, 64'hFFFF_FFFF_FFFF_F00D);
        check("lh_rd", {59'h0, wb_rd_q}, 64'd10);
        tick();
        check("lh_once", {63'h0, wb_valid_q}, 64'h0);

        issue(1'b1, 1'b0, LW, 64'h7000, 64'h0, 5'd11);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", {63'h0, stall_out}, 64'h0);
        check("mid_rst_req", {63'h0, req_valid}, 64'h0);
        #3;
        rst_n = 1'b1;
        resp_valid = 1'b1; resp_rdata = 64'h5555_5555_5555_5555;
        tick();
        resp_valid = 1'b0;
        check("late_resp_valid", {63'h0, wb_valid_q}, 64'h0);
        check("late_resp_stall", {63'h0, stall_out}, 64'h0);
        tick();
        check("late_resp_valid2", {63'h0, wb_valid_q}, 64'h0);
        check("late_resp_data", wb_data_q, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
